// File: rtl/trig_pkg.sv
// ============================================================================
// Module : trig_pkg
// Brief  : Shared FSM encoding and default widths for the echo capture block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package trig_pkg;

    localparam int C_DELAY_W = 16;
    localparam int C_WIDTH_W = 12;

    typedef enum logic [2:0] {
        IDLE      = 3'b001,
        WAIT_ECHO = 3'b010,
        MEASURE   = 3'b100
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// Module : sync_edge
// Brief  : Multi-flop synchroniser followed by an edge register with
//          combinational rise/fall pulses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_edge;

    // Preset to 1 so an input already high at reset release gives no rise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '1;
            r_edge <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_edge <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_edge;
    assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_edge;

endmodule

`default_nettype wire

// File: rtl/echo_capture.sv
// ============================================================================
// Module : echo_capture
// Brief  : Measures trigger-to-echo delay and echo pulse width in clock counts.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module echo_capture
    import trig_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DELAY_W     = C_DELAY_W,
    parameter int WIDTH_W     = C_WIDTH_W
) (
    input  logic               i_clk100M,
    input  logic               i_rst,
    input  logic               i_trig,
    input  logic               i_echo,
    input  logic [DELAY_W-1:0] i_window,
    output logic [DELAY_W-1:0] o_delay,
    output logic [WIDTH_W-1:0] o_width,
    output logic               o_sat,
    output logic               o_valid,
    output logic               o_timeout,
    output logic               o_busy
);

    logic               w_trig_rise;
    logic               w_echo_rise;
    logic               w_echo_fall;

    state_t             r_state;
    logic [DELAY_W-1:0] r_window;
    logic [DELAY_W-1:0] r_delay_cnt;
    logic [DELAY_W-1:0] r_delay_lat;
    logic [WIDTH_W-1:0] r_width_cnt;
    logic [DELAY_W-1:0] r_delay;
    logic [WIDTH_W-1:0] r_width;
    logic               r_sat;
    logic               r_valid;
    logic               r_timeout;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_trig (
        .i_clk  (i_clk100M),
        .i_rst  (i_rst),
        .i_d    (i_trig),
        .o_rise (w_trig_rise),
        .o_fall ()
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_echo (
        .i_clk  (i_clk100M),
        .i_rst  (i_rst),
        .i_d    (i_echo),
        .o_rise (w_echo_rise),
        .o_fall (w_echo_fall)
    );

    always_ff @(posedge i_clk100M or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_window    <= '0;
            r_delay_cnt <= '0;
            r_delay_lat <= '0;
            r_width_cnt <= '0;
            r_delay     <= '0;
            r_width     <= '0;
            r_sat       <= 1'b0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_window  <= i_window;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_trig_rise) begin
                        r_delay_cnt <= DELAY_W'(1);
                        r_state     <= WAIT_ECHO;
                    end
                end
                WAIT_ECHO: begin
                    // Echo is checked first so it wins over a coincident window match.
                    if (w_echo_rise) begin
                        r_delay_lat <= r_delay_cnt;
                        r_width_cnt <= WIDTH_W'(1);
                        r_state     <= MEASURE;
                    end else if ((r_window != '0) && (r_delay_cnt == r_window)) begin
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else if (r_delay_cnt != '1) begin
                        r_delay_cnt <= r_delay_cnt + DELAY_W'(1);
                    end
                end
                MEASURE: begin
                    if (w_echo_fall) begin
                        r_delay <= r_delay_lat;
                        r_width <= r_width_cnt;
                        r_sat   <= (r_width_cnt == '1);
                        r_valid <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_width_cnt != '1) begin
                        r_width_cnt <= r_width_cnt + WIDTH_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_delay   = r_delay;
    assign o_width   = r_width;
    assign o_sat     = r_sat;
    assign o_valid   = r_valid;
    assign o_timeout = r_timeout;
    assign o_busy    = (r_state != IDLE);

endmodule

`default_nettype wire
